// File: rtl/data_port_arbiter.sv
// Two-port arbiter for the Memory data port: grant, issue, wait, ack per access.
// Define ARBITER_ROUND_ROBIN_EN for round-robin conflicts; default is fixed priority with anti-starvation.
//
//  state   | meaning
//  S_IDLE  | no access in flight, sample requests and latch the winner's payload
//  S_ISSUE | drive the latched access onto the memory pins (mem_we pulses for writes)
//  S_WAIT  | count READ_LATENCY cycles, then capture mem_rdata for the owner
//  S_ACK   | one-cycle completion pulse to the owner
module data_port_arbiter #(
  parameter int ADDR_WIDTH   = 14,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int MAX_STREAK   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_ack,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_ack,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  owner
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

  localparam logic [1:0] WAIT_LOAD = 2'(READ_LATENCY - 1);

  state_t     state, state_nxt;
  logic       lat_we;
  logic [1:0] wait_cnt;
  logic       grant;
  logic       grant_port;

  assign grant = (state == S_IDLE) && (p0_req || p1_req);

`ifdef ARBITER_ROUND_ROBIN_EN
  logic rr;

  always_comb begin
    grant_port = p1_req;
    if (p0_req && p1_req) grant_port = rr;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     rr <= 1'b0;
    else if (grant) rr <= ~grant_port;
  end
`else
  localparam int SW = $clog2(MAX_STREAK + 1);
  logic [SW-1:0] streak;

  // Port 1 only overrides port 0 once it has been passed over MAX_STREAK times in a row.
  always_comb begin
    grant_port = p1_req;
    if (p0_req && p1_req) grant_port = (streak == SW'(MAX_STREAK));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      streak <= '0;
    end else if (grant) begin
      if (grant_port || !p1_req) streak <= '0;
      else                       streak <= streak + SW'(1);
    end
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = lat_we ? S_ACK : S_WAIT;
      S_WAIT:  if (wait_cnt == 2'd0) state_nxt = S_ACK;
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != S_IDLE);
    mem_we = (state == S_ISSUE) && lat_we;
    p0_ack = (state == S_ACK) && !owner;
    p1_ack = (state == S_ACK) && owner;
  end

  // Payload is captured straight into the memory-side registers at grant, so later
  // requester changes cannot leak into the access.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner     <= 1'b0;
      lat_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wait_cnt  <= '0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      if (grant) begin
        owner     <= grant_port;
        lat_we    <= grant_port ? p1_we    : p0_we;
        mem_addr  <= grant_port ? p1_addr  : p0_addr;
        mem_wdata <= grant_port ? p1_wdata : p0_wdata;
      end
      if (state == S_ISSUE) begin
        wait_cnt <= WAIT_LOAD;
      end else if (state == S_WAIT) begin
        if (wait_cnt != 2'd0) begin
          wait_cnt <= wait_cnt - 2'd1;
        end else if (owner) begin
          p1_rdata <= mem_rdata;
        end else begin
          p0_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_port_arbiter.sv
// Directed self-checking bench for data_port_arbiter (READ_LATENCY=1 memory model).
module tb_data_port_arbiter;

  logic        clock, reset;
  logic        p0_req, p0_we, p0_ack, p1_req, p1_we, p1_ack;
  logic [13:0] p0_addr, p1_addr, mem_addr;
  logic [31:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, mem_wdata, mem_rdata;
  logic        mem_we, busy, owner;

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl_rd0, mdl_rd1;

  data_port_arbiter dut (
    .clock(clock), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous memory, one cycle read latency; read data is a fixed function of address.
  initial mem_rdata = 32'h0;
  always @(posedge clock) mem_rdata <= 32'h12345658 ^ {18'h0, mem_addr};

  typedef struct {
    logic        p0_req;
    logic        p0_we;
    logic [13:0] p0_addr;
    logic [31:0] p0_wdata;
    logic        p1_req;
    logic        p1_we;
    logic [13:0] p1_addr;
    logic [31:0] p1_wdata;
    logic        exp_owner;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic idle_inputs();
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          cyc;
    int          we_cnt;
    logic        got_ack;
    logic        exp_we;
    logic [13:0] exp_addr, wa;
    logic [31:0] exp_wdata, wd;
    exp_we    = v.exp_owner ? v.p1_we    : v.p0_we;
    exp_addr  = v.exp_owner ? v.p1_addr  : v.p0_addr;
    exp_wdata = v.exp_owner ? v.p1_wdata : v.p0_wdata;
    p0_req = v.p0_req; p0_we = v.p0_we; p0_addr = v.p0_addr; p0_wdata = v.p0_wdata;
    p1_req = v.p1_req; p1_we = v.p1_we; p1_addr = v.p1_addr; p1_wdata = v.p1_wdata;
    cyc = 0; we_cnt = 0; got_ack = 0; wa = '0; wd = '0;
    while (!got_ack && cyc < 12) begin
      @(posedge clock); cyc++;
      @(negedge clock);
      if (mem_we) begin we_cnt++; wa = mem_addr; wd = mem_wdata; end
      if (p0_ack || p1_ack) got_ack = 1;
    end
    chk($sformatf("v%0d_ack_seen", idx), 32'(got_ack), 32'd1);
    chk($sformatf("v%0d_latency", idx), cyc, exp_we ? 32'd2 : 32'd3);
    chk($sformatf("v%0d_owner", idx), 32'(owner), 32'(v.exp_owner));
    chk($sformatf("v%0d_acks", idx), {30'h0, p1_ack, p0_ack},
        v.exp_owner ? 32'd2 : 32'd1);
    chk($sformatf("v%0d_we_pulses", idx), we_cnt, 32'(exp_we));
    if (exp_we) begin
      chk($sformatf("v%0d_waddr", idx), 32'(wa), 32'(exp_addr));
      chk($sformatf("v%0d_wdata", idx), wd, exp_wdata);
    end else begin
      chk($sformatf("v%0d_raddr", idx), 32'(mem_addr), 32'(exp_addr));
      if (v.exp_owner) mdl_rd1 = v.exp_rdata;
      else             mdl_rd0 = v.exp_rdata;
    end
    chk($sformatf("v%0d_p0_rdata", idx), p0_rdata, mdl_rd0);
    chk($sformatf("v%0d_p1_rdata", idx), p1_rdata, mdl_rd1);
    idle_inputs();
    @(posedge clock); @(negedge clock);
    chk($sformatf("v%0d_back_idle", idx), {30'h0, busy, p0_ack | p1_ack}, 32'd0);
  endtask

  vec_t vecs[7];
  int   n;
  int   ack_seen;
  logic ord[10];

  initial begin
    #400000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1, 1, 14'h010,  32'hDEADBEEF, 0, 0, 14'h0,    32'h0,        0, 32'h0};
    vecs[1] = '{0, 0, 14'h0,    32'h0,        1, 0, 14'h020,  32'h0,        1, 32'h12345678};
    vecs[2] = '{1, 0, 14'h3FF,  32'h0,        0, 0, 14'h0,    32'h0,        0, 32'h123455A7};
    vecs[3] = '{0, 0, 14'h0,    32'h0,        1, 1, 14'h2AAA, 32'hCAFEF00D, 1, 32'h0};
    vecs[4] = '{0, 0, 14'h0,    32'h0,        1, 0, 14'h155,  32'h0,        1, 32'h1234570D};
    vecs[5] = '{1, 1, 14'h100,  32'h11111111, 1, 0, 14'h200,  32'h0,        0, 32'h0};
    vecs[6] = '{1, 0, 14'h3FFF, 32'h0,        0, 0, 14'h0,    32'h0,        0, 32'h123469A7};
    mdl_rd0 = '0; mdl_rd1 = '0;

    idle_inputs();
    reset = 0;
    repeat (2) @(negedge clock);
    chk("reset_outputs", {26'h0, busy, owner, mem_we, p0_ack, p1_ack, 1'b0}, 32'd0);
    chk("reset_mem_addr", 32'(mem_addr), 32'd0);
    chk("reset_rdata", p0_rdata | p1_rdata | mem_wdata, 32'd0);
    reset = 1;
    repeat (2) @(negedge clock);
    chk("no_req_idle", 32'(busy), 32'd0);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Write request withdrawn while in ISSUE, payload scrambled after grant.
    p0_req = 1; p0_we = 1; p0_addr = 14'h055; p0_wdata = 32'hA5A5A5A5;
    @(posedge clock); @(negedge clock);
    chk("drop_issue_we", 32'(mem_we), 32'd1);
    chk("drop_issue_addr", 32'(mem_addr), 32'h055);
    chk("drop_issue_wdata", mem_wdata, 32'hA5A5A5A5);
    p0_req = 0; p0_addr = 14'h003; p0_wdata = 32'h0;
    @(posedge clock); @(negedge clock);
    chk("drop_ack", {30'h0, p1_ack, p0_ack}, 32'd1);
    chk("drop_we_off", 32'(mem_we), 32'd0);
    @(posedge clock); @(negedge clock);
    chk("drop_idle", {30'h0, busy, p0_ack}, 32'd0);
    @(posedge clock); @(negedge clock);
    chk("drop_no_restart", 32'(busy), 32'd0);
    idle_inputs();

    // Reset while a port-1 read sits in WAIT.
    p1_req = 1; p1_we = 0; p1_addr = 14'h020;
    @(posedge clock); @(posedge clock); @(negedge clock);
    chk("rst_wait_busy", 32'(busy), 32'd1);
    #2 reset = 0;
    #1;
    chk("rst_async_ctl", {27'h0, busy, owner, mem_we, p0_ack, p1_ack}, 32'd0);
    chk("rst_async_data", p0_rdata | p1_rdata | mem_wdata | 32'(mem_addr), 32'd0);
    p1_req = 0;
    ack_seen = 0;
    repeat (3) begin
      @(negedge clock);
      if (p0_ack || p1_ack) ack_seen++;
    end
    reset = 1;
    repeat (2) begin
      @(negedge clock);
      if (p0_ack || p1_ack) ack_seen++;
    end
    chk("rst_no_ack", ack_seen, 32'd0);
    mdl_rd0 = '0; mdl_rd1 = '0;
    run_vec(7, vecs[1]);

    // Both ports held high: observe the grant order over ten transactions.
    p0_req = 1; p0_we = 1; p0_addr = 14'h001; p0_wdata = 32'h0000AAAA;
    p1_req = 1; p1_we = 1; p1_addr = 14'h002; p1_wdata = 32'h0000BBBB;
    n = 0;
    for (int c = 0; c < 80 && n < 10; c++) begin
      @(posedge clock); @(negedge clock);
      if (p0_ack)      begin ord[n] = 1'b0; n++; end
      else if (p1_ack) begin ord[n] = 1'b1; n++; end
    end
    idle_inputs();
    chk("arb_count", n, 32'd10);
    for (int i = 0; i < n; i++) begin
`ifdef ARBITER_ROUND_ROBIN_EN
      chk($sformatf("arb_order_%0d", i), 32'(ord[i]), 32'(i % 2));
`else
      chk($sformatf("arb_order_%0d", i), 32'(ord[i]), (i % 5 == 4) ? 32'd1 : 32'd0);
`endif
    end
    repeat (3) @(negedge clock);
    chk("final_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
